sample_read_arbiter: RTL and testbench
======================================

Name: sample_read_arbiter

Overview:
- Shares the single read port of the wave-sample BRAM among all requesters, one grant per cycle:
  - NUM_OSCILLATORS oscillator sample fetches,
  - the HDMI waveform visualiser,
  - the UART debugger.
- Sits between the oscillators/viz/debug logic and the wave loader's playback BRAM. It issues a registered address/enable and routes each returning sample back to the requester that asked for it.
- hold_in lets the wave loader freeze new reads while it rewrites the buffer.

Parameters:
- NUM_OSCILLATORS, 4, number of oscillator requesters (>=1).
- SAMPLE_WIDTH, 8, bits per sample.
- ADDR_WIDTH, 15, BRAM address width.
- BRAM_LATENCY, 2, cycles from bram_addr_out driven to bram_data_in valid (>=1).
- STARVE_LIMIT, 16, waiting cycles after which viz/debug is promoted (>=1).

Ports:
- clk_in  input  1  system clock (100 MHz); single clock domain.
- rst_n_in  input  1  reset; asynchronous assert, active-low.
- hold_in  input  1  1 = grant nothing (loader writing BRAM).
- osc_req_in  input  NUM_OSCILLATORS  per-oscillator read request (valid).
- osc_addr_in  input  NUM_OSCILLATORS x ADDR_WIDTH  per-oscillator address.
- osc_ack_out  output  NUM_OSCILLATORS  per-oscillator grant (ready); combinational.
- osc_valid_out  output  NUM_OSCILLATORS  one-cycle response strobe.
- osc_data_out  output  NUM_OSCILLATORS x SAMPLE_WIDTH  last returned sample, held.
- viz_req_in / viz_addr_in / viz_ack_out / viz_valid_out / viz_data_out  as above, 1 / ADDR_WIDTH / 1 / 1 / SAMPLE_WIDTH.
- dbg_req_in / dbg_addr_in / dbg_ack_out / dbg_valid_out / dbg_data_out  as above, for the debugger.
- bram_en_out  output  1  BRAM read enable, registered.
- bram_addr_out  output  ADDR_WIDTH  BRAM read address, registered.
- bram_data_in  input  SAMPLE_WIDTH  BRAM read data.

Behaviour:
- Reset (rst_n_in=0, async):
  - All *_valid_out, *_data_out, bram_en_out and bram_addr_out are 0.
  - Round-robin pointer is 0.
  - Starvation counters are 0.
  - In-flight tag pipeline is cleared; pending responses are discarded and never strobed.
- Handshake:
  - A transfer occurs at edge T when req=1 and ack=1.
  - addr is sampled at T.
  - A requester holds req/addr stable until ack.
  - A requester may keep req high for back-to-back reads.
- ack is combinational from registered state and current reqs.
  - At most one ack is high per cycle.
  - All acks are 0 when hold_in=1.
  - Acks are 0 during reset.
- Arbitration order each cycle:
  1. Promoted dbg, i.e. dbg wait counter >= STARVE_LIMIT.
  2. Promoted viz, on the same rule.
  3. Oscillators, round-robin starting at the pointer.
  4. viz.
  5. dbg.
- Round-robin pointer: on an osc grant to index i, pointer becomes (i+1) mod NUM_OSCILLATORS. It is unchanged otherwise.
- Starvation counters (viz, dbg):
  - Increment (saturating at STARVE_LIMIT) each cycle that req=1, ack=0 and hold_in=0.
  - Clear to 0 on that requester's transfer.
  - Hold their value while hold_in=1.
- Issue: in the cycle after transfer edge T, bram_en_out=1 and bram_addr_out=sampled addr. With no transfer, bram_en_out=0 and bram_addr_out keeps its last value.
- Tag pipeline:
  - Width = clog2(NUM_OSCILLATORS+2) plus a valid bit; depth BRAM_LATENCY+1.
  - Responses return in issue order.
  - A requester may have several reads in flight.
- Response:
  - bram_data_in is captured at edge T+2+BRAM_LATENCY into the tagged requester's data_out.
  - That requester's valid_out is 1 for exactly the cycle following that edge.
  - Other requesters' data_out are unchanged.
  - Latency is a fixed BRAM_LATENCY+2 cycles from the transfer edge (4 at default).
- Throughput: one read per cycle sustained; no bubbles between grants.
- Simultaneous events:
  - A response strobe and a new transfer in the same cycle are independent.
  - A transfer and the promotion threshold in the same cycle resolve by the priority order above.
- hold_in does not affect in-flight reads; they complete and strobe normally.
- Addresses are passed unmodified; range checking is the requester's responsibility.

Test Plan:
- Single osc[2] read, addr 0x0123, BRAM returns 0x5A at default latency:
  - osc_ack_out[2] is high in the req cycle;
  - bram_en_out/bram_addr_out=0x0123 next cycle;
  - osc_valid_out[2] pulses at T+4 with osc_data_out[2]=0x5A;
  - other outputs unchanged.
- All 4 osc req held high continuously with pointer=0 -> grants 0,1,2,3,0,... one per cycle, no gaps; responses return in the same order, each 4 cycles after its grant.
- All osc plus viz req continuous:
  - viz wait counter reaches 16 and viz is granted on the 17th cycle;
  - counter clears;
  - the osc rotation resumes at the pointer it held.
- viz and dbg both promoted in the same cycle -> dbg is granted first, viz the next cycle.
- hold_in raised with 2 reads in flight and reqs pending:
  - no acks while hold_in=1;
  - both in-flight responses still strobe;
  - grants resume the cycle hold_in falls.
- rst_n_in pulled low asynchronously mid-pipeline with 3 reads in flight:
  - all outputs read 0 immediately;
  - no valid strobes after release;
  - the first grant after release goes to osc[0].

Source files
------------

// File: rtl/sample_read_arbiter.sv
// Arbitrates the single wave-sample BRAM read port between the oscillators, the
// HDMI visualiser and the UART debugger, and routes each returned sample home.

module sample_rsp_lane #(
    parameter int SAMPLE_WIDTH = 8
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    hit,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    output logic                    valid,
    output logic [SAMPLE_WIDTH-1:0] data
);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            valid <= hit;
            if (hit) data <= sample;
        end
    end

endmodule

module sample_read_arbiter #(
    parameter int NUM_OSCILLATORS = 4,
    parameter int SAMPLE_WIDTH    = 8,
    parameter int ADDR_WIDTH      = 15,
    parameter int BRAM_LATENCY    = 2,
    parameter int STARVE_LIMIT    = 16
) (
    input  logic                                    clk_in,
    input  logic                                    rst_n_in,
    input  logic                                    hold_in,
    input  logic [NUM_OSCILLATORS-1:0]              osc_req_in,
    input  logic [NUM_OSCILLATORS*ADDR_WIDTH-1:0]   osc_addr_in,
    output logic [NUM_OSCILLATORS-1:0]              osc_ack_out,
    output logic [NUM_OSCILLATORS-1:0]              osc_valid_out,
    output logic [NUM_OSCILLATORS*SAMPLE_WIDTH-1:0] osc_data_out,
    input  logic                                    viz_req_in,
    input  logic [ADDR_WIDTH-1:0]                   viz_addr_in,
    output logic                                    viz_ack_out,
    output logic                                    viz_valid_out,
    output logic [SAMPLE_WIDTH-1:0]                 viz_data_out,
    input  logic                                    dbg_req_in,
    input  logic [ADDR_WIDTH-1:0]                   dbg_addr_in,
    output logic                                    dbg_ack_out,
    output logic                                    dbg_valid_out,
    output logic [SAMPLE_WIDTH-1:0]                 dbg_data_out,
    output logic                                    bram_en_out,
    output logic [ADDR_WIDTH-1:0]                   bram_addr_out,
    input  logic [SAMPLE_WIDTH-1:0]                 bram_data_in
);

    localparam int NUM_REQ = NUM_OSCILLATORS + 2;
    localparam int TAG_W   = $clog2(NUM_REQ);
    localparam int PTR_W   = (NUM_OSCILLATORS > 1) ? $clog2(NUM_OSCILLATORS) : 1;
    localparam int CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [TAG_W-1:0] VIZ_TAG = TAG_W'(NUM_OSCILLATORS);
    localparam logic [TAG_W-1:0] DBG_TAG = TAG_W'(NUM_OSCILLATORS + 1);
    localparam logic [CNT_W-1:0] STARVE  = CNT_W'(STARVE_LIMIT);

    logic [PTR_W-1:0]                   rr_ptr;
    logic [PTR_W-1:0]                   osc_sel;
    logic                               osc_found;
    int                                 idx;
    logic [CNT_W-1:0]                   viz_wait, dbg_wait;
    logic                               viz_promo, dbg_promo;
    logic                               grant;
    logic [TAG_W-1:0]                   grant_tag;
    logic [ADDR_WIDTH-1:0]              grant_addr;
    logic [TAG_W-1:0]                   iss_tag;
    logic [BRAM_LATENCY:0]              vld_pipe;
    logic [BRAM_LATENCY:0][TAG_W-1:0]   tag_pipe;
    logic [NUM_REQ-1:0]                 lane_hit;
    logic [NUM_REQ-1:0]                 lane_valid;
    logic [NUM_REQ-1:0][SAMPLE_WIDTH-1:0] lane_data;

    assign viz_promo = (viz_wait >= STARVE);
    assign dbg_promo = (dbg_wait >= STARVE);

    // Round-robin search starts at rr_ptr and wraps; first requester wins.
    always_comb begin
        osc_found = 1'b0;
        osc_sel   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_OSCILLATORS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_OSCILLATORS) idx = idx - NUM_OSCILLATORS;
            if (!osc_found && osc_req_in[idx]) begin
                osc_found = 1'b1;
                osc_sel   = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        osc_ack_out = '0;
        viz_ack_out = 1'b0;
        dbg_ack_out = 1'b0;
        if (rst_n_in && !hold_in) begin
            if (dbg_req_in && dbg_promo)      dbg_ack_out = 1'b1;
            else if (viz_req_in && viz_promo) viz_ack_out = 1'b1;
            else if (osc_found)               osc_ack_out[osc_sel] = 1'b1;
            else if (viz_req_in)              viz_ack_out = 1'b1;
            else if (dbg_req_in)              dbg_ack_out = 1'b1;
        end
    end

    always_comb begin
        grant      = (|osc_ack_out) | viz_ack_out | dbg_ack_out;
        grant_tag  = TAG_W'(osc_sel);
        grant_addr = osc_addr_in[osc_sel*ADDR_WIDTH +: ADDR_WIDTH];
        if (viz_ack_out) begin
            grant_tag  = VIZ_TAG;
            grant_addr = viz_addr_in;
        end else if (dbg_ack_out) begin
            grant_tag  = DBG_TAG;
            grant_addr = dbg_addr_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rr_ptr <= '0;
        end else if (|osc_ack_out) begin
            rr_ptr <= (osc_sel == PTR_W'(NUM_OSCILLATORS - 1)) ? '0 : osc_sel + 1'b1;
        end
    end

    // Wait counters freeze during hold so the loader does not cause promotions.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            viz_wait <= '0;
            dbg_wait <= '0;
        end else begin
            if (viz_ack_out)
                viz_wait <= '0;
            else if (viz_req_in && !hold_in && viz_wait < STARVE)
                viz_wait <= viz_wait + 1'b1;
            if (dbg_ack_out)
                dbg_wait <= '0;
            else if (dbg_req_in && !hold_in && dbg_wait < STARVE)
                dbg_wait <= dbg_wait + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bram_en_out   <= 1'b0;
            bram_addr_out <= '0;
            iss_tag       <= '0;
        end else begin
            bram_en_out <= grant;
            if (grant) begin
                bram_addr_out <= grant_addr;
                iss_tag       <= grant_tag;
            end
        end
    end

    // Tag travels alongside the read so in-order returns map back to requesters.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[BRAM_LATENCY-1:0], bram_en_out};
            tag_pipe <= {tag_pipe[BRAM_LATENCY-1:0], iss_tag};
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_lane
            assign lane_hit[g] = vld_pipe[BRAM_LATENCY] &&
                                 (tag_pipe[BRAM_LATENCY] == TAG_W'(g));
            sample_rsp_lane #(.SAMPLE_WIDTH(SAMPLE_WIDTH)) u_lane (
                .clk_in   (clk_in),
                .rst_n_in (rst_n_in),
                .hit      (lane_hit[g]),
                .sample   (bram_data_in),
                .valid    (lane_valid[g]),
                .data     (lane_data[g])
            );
        end
        for (g = 0; g < NUM_OSCILLATORS; g++) begin : g_osc_out
            assign osc_valid_out[g]                             = lane_valid[g];
            assign osc_data_out[g*SAMPLE_WIDTH +: SAMPLE_WIDTH] = lane_data[g];
        end
    endgenerate

    assign viz_valid_out = lane_valid[NUM_OSCILLATORS];
    assign viz_data_out  = lane_data[NUM_OSCILLATORS];
    assign dbg_valid_out = lane_valid[NUM_OSCILLATORS+1];
    assign dbg_data_out  = lane_data[NUM_OSCILLATORS+1];

endmodule

// File: tb/tb_sample_read_arbiter.sv
// Directed bench for sample_read_arbiter: expected grants are hand-ordered, responses
// are queued at grant time and checked by an independent strobe monitor.

module tb_sample_read_arbiter;

    localparam int N   = 4;
    localparam int SW  = 8;
    localparam int AW  = 15;
    localparam int LAT = 2;
    localparam int SL  = 16;
    localparam int NONE = 7;
    localparam int VIZ  = 4;
    localparam int DBG  = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            hold;
    logic [N-1:0]    osc_req;
    logic [N*AW-1:0] osc_addr;
    logic [N-1:0]    osc_ack, osc_valid;
    logic [N*SW-1:0] osc_data;
    logic            viz_req, viz_ack, viz_valid;
    logic [AW-1:0]   viz_addr;
    logic [SW-1:0]   viz_data;
    logic            dbg_req, dbg_ack, dbg_valid;
    logic [AW-1:0]   dbg_addr;
    logic [SW-1:0]   dbg_data;
    logic            bram_en;
    logic [AW-1:0]   bram_addr;
    logic [SW-1:0]   bram_data;

    always #5 clk = ~clk;

    sample_read_arbiter #(
        .NUM_OSCILLATORS(N), .SAMPLE_WIDTH(SW), .ADDR_WIDTH(AW),
        .BRAM_LATENCY(LAT), .STARVE_LIMIT(SL)
    ) dut (
        .clk_in(clk), .rst_n_in(rst_n), .hold_in(hold),
        .osc_req_in(osc_req), .osc_addr_in(osc_addr), .osc_ack_out(osc_ack),
        .osc_valid_out(osc_valid), .osc_data_out(osc_data),
        .viz_req_in(viz_req), .viz_addr_in(viz_addr), .viz_ack_out(viz_ack),
        .viz_valid_out(viz_valid), .viz_data_out(viz_data),
        .dbg_req_in(dbg_req), .dbg_addr_in(dbg_addr), .dbg_ack_out(dbg_ack),
        .dbg_valid_out(dbg_valid), .dbg_data_out(dbg_data),
        .bram_en_out(bram_en), .bram_addr_out(bram_addr), .bram_data_in(bram_data)
    );

    function automatic logic [SW-1:0] bram_f(input logic [AW-1:0] a);
        if (a == 15'h0123) return 8'h5A;
        return a[7:0] + 8'h11;
    endfunction

    // BRAM model: data for the address presented after edge T is on the bus
    // for capture at edge T+LAT+2.
    logic [SW-1:0] bpipe [0:LAT];
    always @(posedge clk) begin
        bpipe[0] <= bram_f(bram_addr);
        for (int k = 1; k <= LAT; k++) bpipe[k] <= bpipe[k-1];
    end
    assign bram_data = bpipe[LAT];

    typedef struct {
        int          who;
        logic [SW-1:0] data;
        int          cyc;
    } exp_t;

    exp_t          sb[$];
    int            n_chk = 0;
    int            n_fail = 0;
    int            cyc = 0;
    logic [AW-1:0] base [0:5];
    int            gcnt [0:5];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int r);
        return base[r] + AW'(gcnt[r]);
    endfunction

    function automatic logic [SW-1:0] data_of(input int r);
        if (r < N) return osc_data[r*SW +: SW];
        if (r == VIZ) return viz_data;
        return dbg_data;
    endfunction

    task automatic drive(input logic [N-1:0] oreq, input logic v, input logic d, input logic h);
        osc_req = oreq;
        viz_req = v;
        dbg_req = d;
        hold    = h;
        for (int i = 0; i < N; i++) osc_addr[i*AW +: AW] = addr_of(i);
        viz_addr = addr_of(VIZ);
        dbg_addr = addr_of(DBG);
    endtask

    // One cycle: drive, check the grant at the negedge, queue the response.
    task automatic run_cycle(input logic [N-1:0] oreq, input logic v, input logic d,
                             input logic h, input int exp);
        logic [5:0] expv;
        exp_t       e;
        drive(oreq, v, d, h);
        @(negedge clk);
        expv = (exp == NONE) ? 6'b0 : (6'b1 << exp);
        chk("ack vector", {58'b0, dbg_ack, viz_ack, osc_ack}, {58'b0, expv});
        if (exp != NONE) begin
            e.who  = exp;
            e.data = bram_f(addr_of(exp));
            e.cyc  = cyc + 1 + LAT + 2;
            sb.push_back(e);
            gcnt[exp]++;
        end
        @(posedge clk);
        #1;
    endtask

    // Response monitor
    always @(negedge clk) begin
        logic [5:0] vv;
        int         who;
        exp_t       e;
        vv  = {dbg_valid, viz_valid, osc_valid};
        who = 0;
        if (vv != 6'b0) begin
            for (int i = 0; i < 6; i++) if (vv[i]) who = i;
            if ($countones(vv) != 1) chk("single strobe", 64'($countones(vv)), 64'd1);
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected strobe: requester %0d strobed, none expected (cycle %0d)", who, cyc);
            end else begin
                e = sb.pop_front();
                chk("rsp requester", 64'(who), 64'(e.who));
                chk("rsp data", 64'(data_of(who)), 64'(e.data));
                chk("rsp cycle", 64'(cyc), 64'(e.cyc));
            end
        end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL missing strobe: requester %0d got none, expected one at cycle %0d", e.who, e.cyc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, " bram_en"}, 64'(bram_en), 64'd0);
        chk({tag, " bram_addr"}, 64'(bram_addr), 64'd0);
        chk({tag, " valids"}, 64'({dbg_valid, viz_valid, osc_valid}), 64'd0);
        chk({tag, " osc_data"}, 64'(osc_data), 64'd0);
        chk({tag, " viz/dbg data"}, 64'({viz_data, dbg_data}), 64'd0);
        chk({tag, " acks"}, 64'({dbg_ack, viz_ack, osc_ack}), 64'd0);
    endtask

    initial begin
        base[0] = 15'h1000; base[1] = 15'h2000; base[2] = 15'h3000;
        base[3] = 15'h4000; base[4] = 15'h5000; base[5] = 15'h6000;
        for (int i = 0; i < 6; i++) gcnt[i] = 0;

        // Reset state, with requests asserted to confirm acks are masked
        rst_n = 1'b0;
        drive('1, 1'b1, 1'b1, 1'b0);
        #2;
        chk_all_zero("reset");
        drive('0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single osc[2] read of 0x0123 returning 0x5A
        base[2] = 15'h0123;
        run_cycle(4'b0100, 0, 0, 0, 2);
        chk("issue en", 64'(bram_en), 64'd1);
        chk("issue addr", 64'(bram_addr), 64'h0123);
        run_cycle(4'b0000, 0, 0, 0, NONE);
        chk("idle en", 64'(bram_en), 64'd0);
        chk("held addr", 64'(bram_addr), 64'h0123);
        repeat (4) run_cycle(4'b0000, 0, 0, 0, NONE);
        chk("osc2 data held", 64'(osc_data[2*SW +: SW]), 64'h5A);
        chk("osc0 untouched", 64'(osc_data[0 +: SW]), 64'h00);
        chk("viz untouched", 64'(viz_data), 64'h00);

        // All oscillators continuous: pointer is 3 after the osc[2] grant
        for (int k = 0; k < 8; k++) run_cycle(4'b1111, 0, 0, 0, (3 + k) % 4);

        // Oscillators plus viz: viz promoted on its 17th cycle
        for (int k = 0; k < 16; k++) run_cycle(4'b1111, 1, 0, 0, (3 + k) % 4);
        run_cycle(4'b1111, 1, 0, 0, VIZ);
        run_cycle(4'b1111, 0, 0, 0, 3);
        run_cycle(4'b1111, 0, 0, 0, 0);

        // viz and dbg promoted together: dbg first, then viz
        for (int k = 0; k < 16; k++) run_cycle(4'b1111, 1, 1, 0, (1 + k) % 4);
        run_cycle(4'b1111, 1, 1, 0, DBG);
        run_cycle(4'b1111, 1, 0, 0, VIZ);
        run_cycle(4'b1111, 0, 0, 0, 1);

        // hold with two reads in flight
        run_cycle(4'b1111, 1, 0, 0, 2);
        run_cycle(4'b1111, 1, 0, 0, 3);
        repeat (3) run_cycle(4'b1111, 1, 0, 1, NONE);
        run_cycle(4'b1111, 1, 0, 0, 0);
        run_cycle(4'b0000, 1, 0, 0, VIZ);
        repeat (5) run_cycle(4'b0000, 0, 0, 0, NONE);

        // Asynchronous reset with three reads in flight
        run_cycle(4'b1111, 0, 0, 0, 1);
        run_cycle(4'b1111, 0, 0, 0, 2);
        run_cycle(4'b1111, 0, 0, 0, 3);
        drive('1, 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk_all_zero("mid reset");
        sb.delete();
        drive('0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) run_cycle(4'b0000, 0, 0, 0, NONE);
        run_cycle(4'b1111, 0, 0, 0, 0);
        run_cycle(4'b0000, 0, 0, 0, NONE);

        repeat (8) @(negedge clk);
        chk("scoreboard drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
